// File: rtl/mem_burst_pkg.sv
// Shared types for the multi-nibble RAM burst engine.
package mem_burst_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    READ,
    DRAIN,
    DONE
  } state_t;

  typedef enum logic {
    INC,
    DEC
  } xfer_dir_t;

endpackage

// File: rtl/ptr_step.sv
// Pointer post-step: +/-1 on the low WRAP_BITS, page bits passed through untouched.
module ptr_step #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned WRAP_BITS  = 8
) (
  input  logic [ADDR_WIDTH-1:0] ptr,
  input  logic                  dec,
  output logic [ADDR_WIDTH-1:0] ptr_next_c
);

  logic [WRAP_BITS-1:0] low_c;

  // Low field wraps naturally modulo 2^WRAP_BITS.
  always_comb begin
    low_c = dec ? (ptr[WRAP_BITS-1:0] - WRAP_BITS'(1))
                : (ptr[WRAP_BITS-1:0] + WRAP_BITS'(1));
  end

  generate
    if (WRAP_BITS < ADDR_WIDTH) begin : g_page
      assign ptr_next_c = {ptr[ADDR_WIDTH-1:WRAP_BITS], low_c};
    end else begin : g_flat
      assign ptr_next_c = ADDR_WIDTH'(low_c);
    end
  endgenerate

endmodule

// File: rtl/mem_burst_xfer.sv
// Multi-nibble RAM store/gather engine with post-stepped page-relative pointer.
module mem_burst_xfer
  import mem_burst_pkg::*;
#(
  parameter int unsigned  MAX_NIBBLES = 4,
  parameter int unsigned  ADDR_WIDTH  = 12,
  parameter int unsigned  WRAP_BITS   = 8,
  localparam int unsigned CNT_W       = $clog2(MAX_NIBBLES + 1),
  localparam int unsigned DATA_W      = MAX_NIBBLES * NIBBLE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic                  load,
  input  logic                  dec,
  input  logic [CNT_W-1:0]      count,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ptr_out,
  output logic                  ptr_we,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [NIBBLE_W-1:0]   ram_wdata,
  output logic                  ram_we,
  input  logic [NIBBLE_W-1:0]   ram_rdata
);

  state_t                state_q, state_d;
  xfer_dir_t             dir_q, dir_d;
  logic [CNT_W-1:0]      idx_q, idx_d, cnt_q, cnt_d, idx_inc;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, ptr_out_q, ptr_out_d, ptr_step_c;
  logic [DATA_W-1:0]     wsh_q, wsh_d, rdata_q, rdata_d;
  logic                  busy_q, busy_d, done_q, done_d, ram_we_q, ram_we_d;
  logic                  step_dec;

  assign step_dec = (dir_q == DEC);

  ptr_step #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WRAP_BITS (WRAP_BITS)
  ) u_ptr_step (
    .ptr       (ptr_q),
    .dec       (step_dec),
    .ptr_next_c(ptr_step_c)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    ptr_out_d = ptr_out_q;
    wsh_d     = wsh_q;
    rdata_d   = rdata_q;
    idx_inc   = idx_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dir_d = xfer_dir_t'(dec);
          idx_d = '0;
          cnt_d = (count > CNT_W'(MAX_NIBBLES)) ? CNT_W'(MAX_NIBBLES) : count;
          ptr_d = base_addr;
          wsh_d = wdata;
          if (cnt_d == '0) begin
            state_d = DONE;
          end else if (load) begin
            state_d = READ;
            rdata_d = '0;
          end else begin
            state_d = STORE;
          end
        end
      end
      STORE: begin
        ptr_d = ptr_step_c;
        idx_d = idx_inc;
        wsh_d = wsh_q >> NIBBLE_W;
        if (idx_inc == cnt_q) state_d = DONE;
      end
      READ: begin
        ptr_d = ptr_step_c;
        idx_d = idx_inc;
        if (idx_inc == cnt_q) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read data trails its address by one cycle, so it lands in nibble idx-1.
    if ((state_q == DRAIN) || ((state_q == READ) && (idx_q != '0))) begin
      for (int unsigned k = 0; k < MAX_NIBBLES; k++) begin
        if (idx_q == CNT_W'(k + 1)) rdata_d[k*NIBBLE_W +: NIBBLE_W] = ram_rdata;
      end
    end

    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    ram_we_d = (state_d == STORE);
    if (done_d) ptr_out_d = ptr_d;
  end

  // State and datapath registers; everything holds while clk_en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= INC;
      idx_q     <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      ptr_out_q <= '0;
      wsh_q     <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ram_we_q  <= 1'b0;
    end else if (clk_en) begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      ptr_out_q <= ptr_out_d;
      wsh_q     <= wsh_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ram_we_q  <= ram_we_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ptr_we    = done_q;
  assign ptr_out   = ptr_out_q;
  assign rdata     = rdata_q;
  assign ram_addr  = ptr_q;
  assign ram_wdata = wsh_q[NIBBLE_W-1:0];
  // A write never escapes on a stalled cycle or in the cycle reset aborts the burst.
  assign ram_we    = ram_we_q & clk_en & ~reset;

endmodule
